// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IF) and load/store (LS),
// one transaction at a time; misaligned LS accesses are answered locally with an error.
module mem_arbiter #(
  parameter int CPU_WIDTH  = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req_i,
  input  logic [CPU_WIDTH-1:0] if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rvalid_o,
  output logic [CPU_WIDTH-1:0] if_rdata_o,
  input  logic                 ls_req_i,
  input  logic                 ls_we_i,
  input  logic [1:0]           ls_size_i,
  input  logic [CPU_WIDTH-1:0] ls_addr_i,
  input  logic [CPU_WIDTH-1:0] ls_wdata_i,
  output logic                 ls_gnt_o,
  output logic                 ls_rvalid_o,
  output logic [CPU_WIDTH-1:0] ls_rdata_o,
  output logic                 ls_err_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [CPU_WIDTH-1:0] mem_addr_o,
  output logic [CPU_WIDTH-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [CPU_WIDTH-1:0] mem_rdata_i
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 own_ls_q, own_ls_d;
  logic                 store_q, store_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [3:0]           mem_be_q, mem_be_d;
  logic [CPU_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [CPU_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                 sel_if_s, sel_ls_s;
  logic [SW-1:0]        starve_inc_s;
  logic [CPU_WIDTH-1:0] addr_sel_s;
  logic                 ls_misalign_s;
  logic [3:0]           ls_be_s;
  logic [CPU_WIDTH-1:0] ls_wdata_s;

  // Grant selection: LS wins unless IF has waited through STARVE_MAX LS grants
  always_comb begin
    sel_if_s = 1'b0;
    sel_ls_s = 1'b0;
    if ((state_q == IDLE) && rst_n) begin
      if (if_req_i && (!ls_req_i || (starve_q == STARVE_LIM))) begin
        sel_if_s = 1'b1;
      end else begin
        sel_ls_s = ls_req_i;
      end
    end else begin
      sel_if_s = 1'b0;
      sel_ls_s = 1'b0;
    end
    starve_inc_s = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
    addr_sel_s   = sel_if_s ? if_addr_i : ls_addr_i;
  end

  // LS access decode: byte lanes, store-data replication and alignment
  always_comb begin
    ls_misalign_s = 1'b0;
    ls_be_s       = 4'b1111;
    ls_wdata_s    = ls_wdata_i;
    case (ls_size_i)
      2'd0: begin
        ls_be_s    = 4'b0001 << addr_sel_s[1:0];
        ls_wdata_s = {4{ls_wdata_i[7:0]}};
      end
      2'd1: begin
        ls_misalign_s = addr_sel_s[0];
        ls_be_s       = 4'b0011 << {addr_sel_s[1], 1'b0};
        ls_wdata_s    = {2{ls_wdata_i[15:0]}};
      end
      default: begin
        ls_misalign_s = (addr_sel_s[1:0] != 2'b00);
      end
    endcase
  end

  // Next state, ownership, starvation count and memory request fields
  always_comb begin
    state_d     = state_q;
    own_ls_d    = own_ls_q;
    store_d     = store_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (sel_if_s) begin
          state_d     = REQ;
          own_ls_d    = 1'b0;
          store_d     = 1'b0;
          starve_d    = {SW{1'b0}};
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'b1111;
          mem_addr_d  = {addr_sel_s[CPU_WIDTH-1:2], 2'b00};
          mem_wdata_d = {CPU_WIDTH{1'b0}};
        end else if (sel_ls_s) begin
          own_ls_d = 1'b1;
          store_d  = ls_we_i;
          starve_d = if_req_i ? starve_inc_s : {SW{1'b0}};
          // Misaligned accesses skip memory entirely
          if (ls_misalign_s) begin
            state_d = ERR;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = ls_we_i;
            mem_be_d    = ls_be_s;
            mem_addr_d  = {addr_sel_s[CPU_WIDTH-1:2], 2'b00};
            mem_wdata_d = ls_wdata_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response forwarding to the current owner
  always_comb begin
    if_rvalid_o = 1'b0;
    if_rdata_o  = {CPU_WIDTH{1'b0}};
    ls_rvalid_o = 1'b0;
    ls_rdata_o  = {CPU_WIDTH{1'b0}};
    ls_err_o    = 1'b0;
    case (state_q)
      RESP: begin
        if (mem_rvalid_i && own_ls_q) begin
          ls_rvalid_o = 1'b1;
          ls_rdata_o  = store_q ? {CPU_WIDTH{1'b0}} : mem_rdata_i;
        end else if (mem_rvalid_i) begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = mem_rdata_i;
        end else begin
          ls_rvalid_o = 1'b0;
        end
      end
      ERR: begin
        ls_rvalid_o = 1'b1;
        ls_err_o    = 1'b1;
      end
      default: begin
        ls_err_o = 1'b0;
      end
    endcase
  end

  // State and memory-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      own_ls_q    <= 1'b0;
      store_q     <= 1'b0;
      starve_q    <= {SW{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= {CPU_WIDTH{1'b0}};
      mem_wdata_q <= {CPU_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      own_ls_q    <= own_ls_d;
      store_q     <= store_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_gnt_o    = sel_if_s;
  assign ls_gnt_o    = sel_ls_s;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors and corner sequences, then random traffic
// against a timestamp-based transaction model with a byte-addressed memory.
module tb_mem_arbiter;
  localparam int STARVE_MAX = 2;
  localparam int NCYC       = 600;

  logic        clk, rst_n;
  logic        if_req_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [1:0]  ls_size_i;
  logic [31:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  mem_arbiter #(.CPU_WIDTH(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
  endtask

  // Behavioural memory: word-addressed, byte-writable
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    w = mem_rd(a);
    for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
    mem[a] = w;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } vec_t;

  task automatic wait_gnt(input bit want_ls, input string nm);
    int n = 0;
    #1;
    while (!(want_ls ? ls_gnt_o : if_gnt_o) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check(nm, 32'(want_ls ? ls_gnt_o : if_gnt_o), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    ls_req_i = 1'b1; ls_we_i = v.we; ls_size_i = v.size;
    ls_addr_i = v.addr; ls_wdata_i = v.wdata;
    wait_gnt(1'b1, $sformatf("vec%0d_gnt", idx));
    @(negedge clk);
    ls_req_i = 1'b0;
    if (v.err) begin
      #1;
      check($sformatf("vec%0d_err_rvalid", idx), 32'(ls_rvalid_o), 32'd1);
      check($sformatf("vec%0d_err_flag", idx), 32'(ls_err_o), 32'd1);
      check($sformatf("vec%0d_err_rdata", idx), ls_rdata_o, 32'h0);
      check($sformatf("vec%0d_err_noreq", idx), 32'(mem_req_o), 32'd0);
      @(negedge clk); #1;
      check($sformatf("vec%0d_err_noreq2", idx), 32'(mem_req_o), 32'd0);
      check($sformatf("vec%0d_err_once", idx), 32'(ls_rvalid_o), 32'd0);
      @(negedge clk);
    end else begin
      mem_gnt_i = 1'b1; #1;
      check($sformatf("vec%0d_req", idx), 32'(mem_req_o), 32'd1);
      check($sformatf("vec%0d_addr", idx), mem_addr_o, v.maddr);
      check($sformatf("vec%0d_be", idx), 32'(mem_be_o), 32'(v.be));
      check($sformatf("vec%0d_we", idx), 32'(mem_we_o), 32'(v.we));
      if (v.we) check($sformatf("vec%0d_wdata", idx), mem_wdata_o, v.mwdata);
      @(negedge clk);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; #1;
      check($sformatf("vec%0d_rvalid", idx), 32'(ls_rvalid_o), 32'd1);
      check($sformatf("vec%0d_noerr", idx), 32'(ls_err_o), 32'd0);
      check($sformatf("vec%0d_rdata", idx), ls_rdata_o, v.we ? 32'h0 : 32'hCAFEF00D);
      @(negedge clk);
      mem_rvalid_i = 1'b0;
    end
  endtask

  task automatic run_if(input logic [31:0] addr, input logic [31:0] data, input string nm);
    if_req_i = 1'b1; if_addr_i = addr;
    wait_gnt(1'b0, {nm, "_gnt"});
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
    check({nm, "_req"}, 32'(mem_req_o), 32'd1);
    check({nm, "_addr"}, mem_addr_o, addr);
    check({nm, "_be"}, 32'(mem_be_o), 32'hF);
    check({nm, "_we"}, 32'(mem_we_o), 32'd0);
    @(negedge clk);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = data; #1;
    check({nm, "_rvalid"}, 32'(if_rvalid_o), 32'd1);
    check({nm, "_rdata"}, if_rdata_o, data);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
  endtask

  vec_t vecs[11];
  bit   own_exp[6];

  // Random-phase model state
  int          free_at, t_gr, t_g, t_r, streak, nb;
  int          if_grants, ls_grants, if_done, ls_done, pulses;
  bit          t_err, t_ls, t_st, drop_if, drop_ls, in_resp;
  bit          e_if_g, e_ls_g, e_mreq, e_rv, e_err;
  logic [31:0] t_addr, t_wd, word;
  logic [3:0]  t_be;
  logic [7:0]  be_w;

  initial begin
    vecs[0]  = '{1'b1, 2'd0, 32'h203, 32'h000000A5, 1'b0, 4'b1000, 32'h200, 32'hA5A5A5A5};
    vecs[1]  = '{1'b1, 2'd1, 32'h202, 32'h00001234, 1'b0, 4'b1100, 32'h200, 32'h12341234};
    vecs[2]  = '{1'b0, 2'd2, 32'h102, 32'h0,        1'b1, 4'b0000, 32'h0,   32'h0};
    vecs[3]  = '{1'b1, 2'd2, 32'h104, 32'h89ABCDEF, 1'b0, 4'b1111, 32'h104, 32'h89ABCDEF};
    vecs[4]  = '{1'b1, 2'd0, 32'h010, 32'h11223377, 1'b0, 4'b0001, 32'h010, 32'h77777777};
    vecs[5]  = '{1'b1, 2'd1, 32'h012, 32'hFFFF8001, 1'b0, 4'b1100, 32'h010, 32'h80018001};
    vecs[6]  = '{1'b0, 2'd1, 32'h031, 32'h0,        1'b1, 4'b0000, 32'h0,   32'h0};
    vecs[7]  = '{1'b1, 2'd3, 32'h040, 32'hCAFE0001, 1'b0, 4'b1111, 32'h040, 32'hCAFE0001};
    vecs[8]  = '{1'b1, 2'd3, 32'h042, 32'h12345678, 1'b1, 4'b0000, 32'h0,   32'h0};
    vecs[9]  = '{1'b0, 2'd0, 32'h033, 32'h0,        1'b0, 4'b1000, 32'h030, 32'h0};
    vecs[10] = '{1'b1, 2'd1, 32'h021, 32'h0000BEEF, 1'b1, 4'b0000, 32'h0,   32'h0};
    own_exp  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset: requests present but nothing may be granted or driven
    rst_n = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h100; ls_req_i = 1'b1;
    ls_we_i = 1'b1; ls_size_i = 2'd2; ls_addr_i = 32'h200; ls_wdata_i = 32'h55;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_if_gnt", 32'(if_gnt_o), 32'd0);
    check("rst_ls_gnt", 32'(ls_gnt_o), 32'd0);
    check("rst_if_rvalid", 32'(if_rvalid_o), 32'd0);
    check("rst_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    check("rst_ls_err", 32'(ls_err_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_be", 32'(mem_be_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_wdata", mem_wdata_o, 32'h0);
    check("rst_rdata", if_rdata_o | ls_rdata_o, 32'h0);
    @(negedge clk);
    if_req_i = 1'b0; ls_req_i = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
    run_if(32'h100, 32'hDEADBEEF, "if_basic");

    // Both requesters busy continuously: LS, LS, IF repeating
    if_req_i = 1'b1; if_addr_i = 32'h300;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'd2; ls_addr_i = 32'h400;
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      #1;
      while (!(if_gnt_o || ls_gnt_o) && n < 10) begin
        @(negedge clk); #1; n++;
      end
      check($sformatf("both_ls_gnt%0d", k), 32'(ls_gnt_o), 32'(own_exp[k]));
      check($sformatf("both_if_gnt%0d", k), 32'(if_gnt_o), 32'(!own_exp[k]));
      @(negedge clk);
      mem_gnt_i = 1'b1; #1;
      check($sformatf("both_addr%0d", k), mem_addr_o, own_exp[k] ? 32'h400 : 32'h300);
      @(negedge clk);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1000 + 32'(k); #1;
      check($sformatf("both_rv_ls%0d", k), 32'(ls_rvalid_o), 32'(own_exp[k]));
      check($sformatf("both_rv_if%0d", k), 32'(if_rvalid_o), 32'(!own_exp[k]));
      @(negedge clk);
      mem_rvalid_i = 1'b0;
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;
    @(negedge clk);

    // Memory stall: fields hold for 5 cycles, stray rvalid ignored, one response
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_size_i = 2'd0; ls_addr_i = 32'h501; ls_wdata_i = 32'h5C;
    wait_gnt(1'b1, "stall_gnt");
    @(negedge clk);
    ls_req_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      mem_rvalid_i = (s == 2); #1;
      check("stall_req", 32'(mem_req_o), 32'd1);
      check("stall_addr", mem_addr_o, 32'h500);
      check("stall_be", 32'(mem_be_o), 32'h2);
      check("stall_wdata", mem_wdata_o, 32'h5C5C5C5C);
      check("stall_no_rvalid", 32'(ls_rvalid_o), 32'd0);
      @(negedge clk);
    end
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; #1;
    check("stall_req_at_gnt", 32'(mem_req_o), 32'd1);
    @(negedge clk);
    mem_gnt_i = 1'b0; pulses = 0;
    for (int s = 0; s < 6; s++) begin
      mem_rvalid_i = (s == 2); #1;
      if (s == 0) check("stall_req_dropped", 32'(mem_req_o), 32'd0);
      if (ls_rvalid_o) pulses++;
      @(negedge clk);
    end
    mem_rvalid_i = 1'b0;
    check("stall_one_pulse", 32'(pulses), 32'd1);

    // Reset while REQ is pending: mem_req_o must drop at once
    if_req_i = 1'b1; if_addr_i = 32'h700;
    wait_gnt(1'b0, "rstreq_gnt");
    @(negedge clk);
    if_req_i = 1'b0; #1;
    check("rstreq_req_up", 32'(mem_req_o), 32'd1);
    rst_n = 1'b0; #1;
    check("rstreq_req_drop", 32'(mem_req_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during RESP: the pending response is lost
    if_req_i = 1'b1; if_addr_i = 32'h704;
    wait_gnt(1'b0, "rstresp_gnt");
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0; rst_n = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111; #1;
    check("rstresp_no_rvalid", 32'(if_rvalid_o), 32'd0);
    check("rstresp_no_req", 32'(mem_req_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    check("rstresp_no_rvalid_after", 32'(if_rvalid_o), 32'd0);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    run_if(32'h708, 32'h600DF00D, "after_rst");

    // Random traffic against the transaction model
    free_at = 0; t_gr = -10; t_g = -10; t_r = -10; streak = 0;
    t_err = 1'b0; t_ls = 1'b0; t_st = 1'b0; t_addr = 32'h0; t_wd = 32'h0; t_be = 4'h0;
    drop_if = 1'b0; drop_ls = 1'b0;
    if_grants = 0; ls_grants = 0; if_done = 0; ls_done = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (drop_if) if_req_i = 1'b0;
      if (drop_ls) ls_req_i = 1'b0;
      drop_if = 1'b0; drop_ls = 1'b0;
      if (c < NCYC - 24) begin
        if (!if_req_i && $urandom_range(2) == 0) begin
          if_req_i = 1'b1; if_addr_i = 32'h1000 + 32'($urandom_range(63)) * 32'd4;
        end
        if (!ls_req_i && $urandom_range(2) == 0) begin
          ls_req_i = 1'b1; ls_we_i = 1'($urandom_range(1)); ls_size_i = 2'($urandom_range(3));
          ls_addr_i = 32'h1000 + 32'($urandom_range(63)); ls_wdata_i = $urandom;
        end
      end
      in_resp = !t_err && (c > t_g) && (c <= t_r);
      e_rv = !t_err && (c == t_r);
      mem_gnt_i = !t_err && (c == t_g);
      mem_rvalid_i = e_rv || (!in_resp && $urandom_range(7) == 0);
      word = mem_rd(t_addr);
      mem_rdata_i = e_rv ? word : $urandom;
      e_if_g = (c >= free_at) && if_req_i && (!ls_req_i || streak >= STARVE_MAX);
      e_ls_g = (c >= free_at) && ls_req_i && !e_if_g;
      e_mreq = !t_err && (c > t_gr) && (c <= t_g);
      e_err  = t_err && (c == t_gr + 1);
      #1;
      check("rnd_if_gnt", 32'(if_gnt_o), 32'(e_if_g));
      check("rnd_ls_gnt", 32'(ls_gnt_o), 32'(e_ls_g));
      check("rnd_if_rvalid", 32'(if_rvalid_o), 32'(e_rv && !t_ls));
      check("rnd_ls_rvalid", 32'(ls_rvalid_o), 32'((e_rv && t_ls) || e_err));
      check("rnd_ls_err", 32'(ls_err_o), 32'(e_err));
      check("rnd_mem_req", 32'(mem_req_o), 32'(e_mreq));
      if (e_mreq) begin
        check("rnd_mem_addr", mem_addr_o, t_addr);
        check("rnd_mem_be", 32'(mem_be_o), 32'(t_be));
        check("rnd_mem_we", 32'(mem_we_o), 32'(t_st));
        if (t_st) check("rnd_mem_wdata", mem_wdata_o, t_wd);
      end
      if (e_rv && t_ls) check("rnd_ls_rdata", ls_rdata_o, t_st ? 32'h0 : word);
      if (e_rv && !t_ls) check("rnd_if_rdata", if_rdata_o, word);
      if (e_err) check("rnd_err_rdata", ls_rdata_o, 32'h0);
      if (if_rvalid_o) if_done++;
      if (ls_rvalid_o) ls_done++;
      if (e_rv && t_st) mem_wr(t_addr, t_be, t_wd);
      if (e_if_g || e_ls_g) begin
        t_gr = c; t_ls = e_ls_g;
        if (e_if_g) begin
          t_addr = if_addr_i & 32'hFFFF_FFFC; t_be = 4'hF; t_st = 1'b0; t_err = 1'b0;
          streak = 0; drop_if = 1'b1; if_grants++;
        end else begin
          nb = (ls_size_i == 2'd0) ? 1 : (ls_size_i == 2'd1) ? 2 : 4;
          t_err = (int'(ls_addr_i % 32'd4) % nb) != 0;
          t_addr = ls_addr_i & 32'hFFFF_FFFC;
          be_w = ((8'd1 << nb) - 8'd1) << ls_addr_i[1:0];
          t_be = be_w[3:0];
          t_st = ls_we_i;
          for (int i = 0; i < 4; i++) t_wd[i*8 +: 8] = ls_wdata_i[(i % nb)*8 +: 8];
          streak = if_req_i ? ((streak + 1 > STARVE_MAX) ? STARVE_MAX : streak + 1) : 0;
          drop_ls = 1'b1; ls_grants++;
        end
        if (t_err) begin
          t_g = -10; t_r = -10; free_at = c + 2;
        end else begin
          t_g = c + 1 + int'($urandom_range(3));
          t_r = t_g + 1 + int'($urandom_range(2));
          free_at = t_r + 1;
        end
      end
      @(negedge clk);
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;
    check("rnd_if_all_done", 32'(if_done), 32'(if_grants));
    check("rnd_ls_all_done", 32'(ls_done), 32'(ls_grants));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
